// File: rtl/dram_req_buffer_if.sv
// Cache-side and backend-side handshake bundle for dram_req_buffer.
// slave = the buffer's view; master = the cache/backend view driving it.
interface dram_req_buffer_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
);
    logic              m_req_en;
    logic              m_req_cmd;
    logic [ADDR_W-1:0] m_req_addr;
    logic [DATA_W-1:0] m_req_data;
    logic              m_req_rdy;
    logic              m_rsp_en;
    logic [DATA_W-1:0] m_rsp_data;
    logic              m_rsp_rdy;
    logic              s_req_en;
    logic              s_req_cmd;
    logic [ADDR_W-1:0] s_req_addr;
    logic [DATA_W-1:0] s_req_data;
    logic              s_req_rdy;
    logic              s_rsp_en;
    logic [DATA_W-1:0] s_rsp_data;
    logic              s_rsp_rdy;

    modport slave (
        input  m_req_en, m_req_cmd, m_req_addr, m_req_data, m_rsp_rdy,
        input  s_req_rdy, s_rsp_en, s_rsp_data,
        output m_req_rdy, m_rsp_en, m_rsp_data,
        output s_req_en, s_req_cmd, s_req_addr, s_req_data, s_rsp_rdy
    );

    modport master (
        output m_req_en, m_req_cmd, m_req_addr, m_req_data, m_rsp_rdy,
        output s_req_rdy, s_rsp_en, s_rsp_data,
        input  m_req_rdy, m_rsp_en, m_rsp_data,
        input  s_req_en, s_req_cmd, s_req_addr, s_req_data, s_rsp_rdy
    );
endinterface

// File: rtl/dram_req_buffer.sv
// Dual FWFT FIFOs: cache->backend commands, backend->cache read lines; 1-cycle push-to-head.
// rdy = not full; strobes into a full FIFO are dropped and latch the sticky overflow flag.
module dram_req_buffer #(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128
) (
    input  logic               clk,
    input  logic               reset,
    dram_req_buffer_if.slave   bus,
    output logic               overflow
);
    localparam int REQ_AW = $clog2(REQ_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam logic [REQ_AW:0] REQ_FULL = (REQ_AW+1)'(REQ_DEPTH);
    localparam logic [RSP_AW:0] RSP_FULL = (RSP_AW+1)'(RSP_DEPTH);

    typedef struct packed {
        logic              cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              req_mem_q [REQ_DEPTH];
    logic [DATA_W-1:0] rsp_mem_q [RSP_DEPTH];

    logic [REQ_AW-1:0] req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
    logic [REQ_AW:0]   req_cnt_q, req_cnt_d;
    logic [RSP_AW-1:0] rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
    logic [RSP_AW:0]   rsp_cnt_q, rsp_cnt_d;
    logic              overflow_q, overflow_d;

    logic req_full, req_empty, rsp_full, rsp_empty;
    logic req_push, req_pop, rsp_push, rsp_pop;
    req_t req_head;

    assign req_full  = (req_cnt_q == REQ_FULL);
    assign req_empty = (req_cnt_q == '0);
    assign rsp_full  = (rsp_cnt_q == RSP_FULL);
    assign rsp_empty = (rsp_cnt_q == '0);

    assign req_push = bus.m_req_en && !req_full;
    assign req_pop  = bus.s_req_rdy && !req_empty;
    assign rsp_push = bus.s_rsp_en && !rsp_full;
    assign rsp_pop  = bus.m_rsp_rdy && !rsp_empty;

    always_comb begin
        req_wptr_d = req_wptr_q;
        req_rptr_d = req_rptr_q;
        req_cnt_d  = req_cnt_q;
        rsp_wptr_d = rsp_wptr_q;
        rsp_rptr_d = rsp_rptr_q;
        rsp_cnt_d  = rsp_cnt_q;
        // A strobe against a full FIFO is lost, so the flag records it until reset.
        overflow_d = overflow_q | (bus.m_req_en & req_full) | (bus.s_rsp_en & rsp_full);

        if (req_push) req_wptr_d = req_wptr_q + 1'b1;
        if (req_pop)  req_rptr_d = req_rptr_q + 1'b1;
        if (req_push && !req_pop)      req_cnt_d = req_cnt_q + 1'b1;
        else if (!req_push && req_pop) req_cnt_d = req_cnt_q - 1'b1;

        if (rsp_push) rsp_wptr_d = rsp_wptr_q + 1'b1;
        if (rsp_pop)  rsp_rptr_d = rsp_rptr_q + 1'b1;
        if (rsp_push && !rsp_pop)      rsp_cnt_d = rsp_cnt_q + 1'b1;
        else if (!rsp_push && rsp_pop) rsp_cnt_d = rsp_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_wptr_q <= '0;
            req_rptr_q <= '0;
            req_cnt_q  <= '0;
            rsp_wptr_q <= '0;
            rsp_rptr_q <= '0;
            rsp_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_wptr_q <= req_wptr_d;
            req_rptr_q <= req_rptr_d;
            req_cnt_q  <= req_cnt_d;
            rsp_wptr_q <= rsp_wptr_d;
            rsp_rptr_q <= rsp_rptr_d;
            rsp_cnt_q  <= rsp_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the zeroed counts keep stale entries unreachable.
    always_ff @(posedge clk) begin
        if (!reset && req_push)
            req_mem_q[req_wptr_q] <= '{cmd: bus.m_req_cmd, addr: bus.m_req_addr, data: bus.m_req_data};
        if (!reset && rsp_push)
            rsp_mem_q[rsp_wptr_q] <= bus.s_rsp_data;
    end

    assign req_head = req_empty ? '0 : req_mem_q[req_rptr_q];

    assign bus.m_req_rdy  = !req_full;
    assign bus.s_rsp_rdy  = !rsp_full;
    assign bus.s_req_en   = !req_empty;
    assign bus.m_rsp_en   = !rsp_empty;
    assign bus.s_req_cmd  = req_head.cmd;
    assign bus.s_req_addr = req_head.addr;
    assign bus.s_req_data = req_head.data;
    assign bus.m_rsp_data = rsp_empty ? '0 : rsp_mem_q[rsp_rptr_q];
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_dram_req_buffer.sv
// Directed bench for dram_req_buffer: command path, response path, full/overflow, wrap, reset.
module tb_dram_req_buffer;
    logic clk = 1'b0;
    logic reset;
    logic overflow;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    dram_req_buffer_if #(.ADDR_W(27), .DATA_W(128)) bus ();

    dram_req_buffer #(
        .REQ_DEPTH(4), .RSP_DEPTH(4), .ADDR_W(27), .DATA_W(128)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " m_req_rdy"}, bus.m_req_rdy, 1);
        chk({tag, " s_rsp_rdy"}, bus.s_rsp_rdy, 1);
        chk({tag, " s_req_en"}, bus.s_req_en, 0);
        chk({tag, " m_rsp_en"}, bus.m_rsp_en, 0);
        chk({tag, " overflow"}, overflow, 0);
        chk({tag, " s_req_cmd"}, bus.s_req_cmd, 0);
        chk({tag, " s_req_addr"}, bus.s_req_addr, 0);
        chk({tag, " s_req_data"}, bus.s_req_data, 0);
        chk({tag, " m_rsp_data"}, bus.m_rsp_data, 0);
    endtask

    localparam logic [127:0] RSP_PAT = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

    initial begin
        reset = 1'b1;
        bus.m_req_en = 0; bus.m_req_cmd = 0; bus.m_req_addr = '0; bus.m_req_data = '0;
        bus.m_rsp_rdy = 0; bus.s_req_rdy = 0; bus.s_rsp_en = 0; bus.s_rsp_data = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_idle("reset");

        // Single read command, held until backend accepts.
        bus.m_req_en = 1; bus.m_req_cmd = 1; bus.m_req_addr = 27'h0001230; bus.m_req_data = 128'hAA;
        tick();
        bus.m_req_en = 0;
        chk("rd s_req_en", bus.s_req_en, 1);
        chk("rd s_req_cmd", bus.s_req_cmd, 1);
        chk("rd s_req_addr", bus.s_req_addr, 27'h0001230);
        tick();
        chk("rd held", bus.s_req_en, 1);
        bus.s_req_rdy = 1;
        tick();
        bus.s_req_rdy = 0;
        chk("rd popped en", bus.s_req_en, 0);
        chk("rd popped addr", bus.s_req_addr, 0);

        // Fill with four writes, then one dropped strobe.
        bus.m_req_cmd = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.m_req_en = 1; bus.m_req_addr = 27'(i * 8); bus.m_req_data = 128'(i);
            tick();
        end
        chk("full m_req_rdy", bus.m_req_rdy, 0);
        chk("full no ovf yet", overflow, 0);
        chk("full head", bus.s_req_data, 1);
        bus.m_req_data = 128'h5; bus.m_req_addr = 27'h28;
        tick();
        bus.m_req_en = 0;
        chk("5th ovf", overflow, 1);
        chk("5th still full", bus.m_req_rdy, 0);
        bus.s_req_rdy = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain en", bus.s_req_en, 1);
            chk("drain data", bus.s_req_data, 128'(i));
            chk("drain addr", bus.s_req_addr, 27'(i * 8));
            tick();
        end
        chk("drain empty", bus.s_req_en, 0);

        // Streaming push/pop across pointer wrap; occupancy stays at one.
        for (int i = 0; i < 10; i++) begin
            bus.m_req_en = 1; bus.m_req_data = 128'(100 + i);
            tick();
            chk("stream en", bus.s_req_en, 1);
            chk("stream data", bus.s_req_data, 128'(100 + i));
            chk("stream rdy", bus.m_req_rdy, 1);
        end
        bus.m_req_en = 0;
        tick();
        bus.s_req_rdy = 0;
        chk("stream empty", bus.s_req_en, 0);
        chk("ovf sticky", overflow, 1);

        // Response held while the cache stalls.
        bus.s_rsp_en = 1; bus.s_rsp_data = RSP_PAT;
        tick();
        bus.s_rsp_en = 0;
        chk("rsp en", bus.m_rsp_en, 1);
        chk("rsp data", bus.m_rsp_data, RSP_PAT);
        tick(); tick();
        chk("rsp stall en", bus.m_rsp_en, 1);
        chk("rsp stall data", bus.m_rsp_data, RSP_PAT);
        bus.m_rsp_rdy = 1;
        tick();
        bus.m_rsp_rdy = 0;
        chk("rsp popped", bus.m_rsp_en, 0);
        chk("rsp popped data", bus.m_rsp_data, 0);

        // Reset with both FIFOs partly occupied.
        bus.m_req_en = 1; bus.s_rsp_en = 1;
        for (int i = 0; i < 2; i++) begin
            bus.m_req_data = 128'(200 + i); bus.s_rsp_data = 128'(300 + i);
            tick();
        end
        bus.m_req_en = 0; bus.s_rsp_en = 0;
        chk("pre-rst req", bus.s_req_en, 1);
        chk("pre-rst rsp", bus.m_rsp_en, 1);
        reset = 1;
        tick();
        chk_idle("midrst");
        reset = 0;
        tick();
        chk_idle("postrst");

        // Empty FIFO: push with a simultaneous pop request is push-only.
        bus.m_req_en = 1; bus.m_req_data = 128'h77; bus.s_req_rdy = 1;
        tick();
        bus.m_req_en = 0;
        chk("empty pp en", bus.s_req_en, 1);
        chk("empty pp data", bus.s_req_data, 128'h77);
        tick();
        bus.s_req_rdy = 0;
        chk("empty pp popped", bus.s_req_en, 0);

        // Response FIFO: full with simultaneous pop and push.
        bus.s_rsp_en = 1;
        for (int i = 1; i <= 4; i++) begin
            bus.s_rsp_data = 128'(400 + i);
            tick();
        end
        chk("rsp full rdy", bus.s_rsp_rdy, 0);
        chk("rsp full ovf", overflow, 0);
        bus.s_rsp_data = 128'(405); bus.m_rsp_rdy = 1;
        tick();
        bus.s_rsp_en = 0;
        chk("rsp fpp ovf", overflow, 1);
        chk("rsp fpp rdy", bus.s_rsp_rdy, 1);
        for (int i = 2; i <= 4; i++) begin
            chk("rsp drain en", bus.m_rsp_en, 1);
            chk("rsp drain data", bus.m_rsp_data, 128'(400 + i));
            tick();
        end
        bus.m_rsp_rdy = 0;
        chk("rsp drain empty", bus.m_rsp_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/dram_req_buffer.md
# dram_req_buffer

Single-clock, dual-direction FIFO buffer between the cache line controller and the DRAM command backend. The cache pushes line-granular read/write commands and pops returned read lines; the backend pops commands and pushes read lines. Both directions are first-word-fall-through queues with valid/ready-style handshakes. The buffer decouples the cache's single-cycle command strobes from backend stalls.

## Interface

Parameters:
- REQ_DEPTH, 4, command FIFO entries (power of two, ≥2)
- RSP_DEPTH, 4, response FIFO entries (power of two, ≥2)
- ADDR_W, 27, command address width: line address {addr[27:4], 3'b0}
- DATA_W, 128, line data width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- m_req_en  in  1  cache command strobe
- m_req_cmd  in  1  1 = read line, 0 = write line
- m_req_addr  in  ADDR_W  line address
- m_req_data  in  DATA_W  write data (ignored for reads, stored anyway)
- m_req_rdy  out  1  command FIFO not full
- m_rsp_en  out  1  response available
- m_rsp_data  out  DATA_W  head response line
- m_rsp_rdy  in  1  cache consumes head response
- s_req_en  out  1  command available
- s_req_cmd  out  1  head command type
- s_req_addr  out  ADDR_W  head command address
- s_req_data  out  DATA_W  head command data
- s_req_rdy  in  1  backend consumes head command
- s_rsp_en  in  1  backend response strobe
- s_rsp_data  in  DATA_W  read line from DRAM
- s_rsp_rdy  out  1  response FIFO not full
- overflow  out  1  sticky: a strobe arrived while its FIFO was full

## Operation

- Command FIFO stores {cmd, addr, data}; response FIFO stores data. Strict FIFO order, no reordering.
- Push: `*_en && *_rdy` at a rising edge writes the entry at the write pointer; pointer increments modulo depth.
- Pop: head valid (`en` out high) && consumer `rdy` high at a rising edge removes the head; pointer increments modulo depth.
- Occupancy counter per FIFO, range 0..DEPTH. Full = count==DEPTH, empty = count==0.
- `m_req_rdy` = !cmd_full; `s_rsp_rdy` = !rsp_full; `s_req_en` = !cmd_empty; `m_rsp_en` = !rsp_empty.
- Head outputs (s_req_cmd/addr/data, m_rsp_data) show the entry at the read pointer when non-empty and are driven to 0 when empty.
- A strobe (m_req_en or s_rsp_en) while the corresponding FIFO is full is dropped, FIFO unchanged, and `overflow` is set. It is cleared only by reset.
- Pop requests while empty are ignored.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur, count unchanged.
- Full FIFO with simultaneous pop and push: pop occurs, push is rejected because rdy was low, and overflow is set. Count becomes DEPTH-1.
- Empty FIFO with push and pop request: push only. The entry becomes visible next cycle.

## Timing

- Reset (synchronous, priority over all activity): pointers and counts 0; m_req_rdy=1, s_rsp_rdy=1, s_req_en=0, m_rsp_en=0, head data outputs 0, overflow=0. Storage contents need not be cleared.
- All status and head outputs are registered-state derived, with no combinational path from `*_en`/`*_rdy` inputs to outputs.
- Latency: entry pushed at edge N is visible on the consumer side after edge N (usable at edge N+1).
- Throughput: one push and one pop per FIFO per cycle.
- Pointer wrap-around is seamless; ordering is preserved across wrap.

## Test plan

- Reset then idle -> m_req_rdy=1, s_rsp_rdy=1, s_req_en=0, m_rsp_en=0, overflow=0, heads 0.
- Push read cmd addr 27'h0001230 with s_req_rdy=0 -> next cycle s_req_en=1, s_req_cmd=1, s_req_addr=27'h0001230. Assert s_req_rdy for one cycle -> s_req_en=0.
- Push 4 writes with data 128'h1..128'h4 and no pops -> m_req_rdy=0 after the 4th. A 5th strobe is dropped and overflow=1. Popping yields data 1,2,3,4 in order.
- Continuous push and pop over 10 entries (pointer wrap) -> output order matches input order, and count never exceeds 1.
- Backend pushes response 128'hDEADBEEF_… while m_rsp_rdy=0 -> m_rsp_en held high with data stable. Set m_rsp_rdy=1 -> popped next edge.
- Assert reset mid-traffic with both FIFOs partly full -> the next cycle shows all reset values, and stale entries never reappear.
